// File: rtl/control_unit_main_multicycle_mips_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit: state codes,
// opcodes, ALU-control op codes, mux select encodings and the control bundle.
package control_unit_main_multicycle_mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_ADDI_EX  = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_RT       = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // All datapath controls driven by the FSM in one bundle.
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

    // States that wait on the memory handshake and are covered by the timeout.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/control_unit_main_multicycle_mips_mem_wait_timer.sv
// Counts cycles spent waiting on memory, flags the abort condition and
// produces the registered one-cycle timeout pulse.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic waiting,      // FSM sits in a memory-handshake state
    input  logic mem_ready,
    input  logic clear,        // FSM changes state this cycle
    output logic expired,      // abort the access at the coming edge
    output logic mem_timeout   // registered pulse, one cycle after abort
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Ready always wins over the limit, so expiry requires ready still low.
    assign expired = waiting && !mem_ready && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

    // Next count: restart on any state change or abort, else count idle waits.
    always_comb begin
        cnt_d = cnt_q;
        if (clear || expired) begin
            cnt_d = '0;
        end else if (waiting && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter and pulse flop.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            mem_timeout <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            mem_timeout <= expired;
        end
    end

endmodule

// File: rtl/control_unit_main_multicycle_mips.sv
// Multi-cycle MIPS main control FSM: fetch/decode/execute/memory/writeback
// sequencing, datapath control decode and fault pulses for the watchdog.
module control_unit_main_multicycle_mips
    import control_unit_main_multicycle_mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output logic       o_pc_write,
    output logic       o_pc_write_cond,
    output logic       o_i_or_d,
    output logic       o_mem_read,
    output logic       o_mem_write,
    output logic       o_ir_write,
    output logic       o_mem_to_reg,
    output logic       o_reg_dst,
    output logic       o_reg_write,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic [1:0] o_alu_op_code,
    output logic [1:0] o_pc_src,
    output logic [3:0] o_state,
    output logic       o_illegal_op,
    output logic       o_mem_timeout
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_out;
    logic   illegal_d;
    logic   illegal_q;
    logic   expired;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait_timer (
        .clk         (i_clk),
        .rst_n       (i_reset_n),
        .waiting     (is_mem_wait_state(state_q)),
        .mem_ready   (i_mem_ready),
        .clear       (state_d != state_q),
        .expired     (expired),
        .mem_timeout (o_mem_timeout)
    );

    // State register and illegal-op pulse flop.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and control decode.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        ctrl      = '0;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRC_B_FOUR;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_SRC_ALU;
                // IR and PC only capture on the cycle the memory actually delivers.
                ctrl.ir_write  = i_mem_ready;
                ctrl.pc_write  = i_mem_ready;
                if (i_mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRC_B_IMM_SHL2;
                ctrl.alu_op    = ALU_ADD;
                case (i_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                // Opcode must be held stable; a change here is treated as illegal.
                if (i_opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (i_opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d   = S_FETCH;
                    illegal_d = 1'b1;
                end
            end
            S_MEMREAD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (i_mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (i_mem_ready) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_RT;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_BEQ: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRC_B_RT;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PC_SRC_ALUOUT;
                state_d            = S_FETCH;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRC_B_IMM;
                ctrl.alu_op    = ALU_ADD;
                state_d        = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_JUMP;
                state_d       = S_FETCH;
            end
            default: begin
                // Codes 12-15: recover to fetch and report it.
                state_d   = S_FETCH;
                illegal_d = 1'b1;
            end
        endcase
        // Abort only fires with ready low, when no write enable is active anyway.
        if (expired) state_d = S_FETCH;
    end

    // Reset forces every control low immediately, independent of the clock.
    assign ctrl_out = i_reset_n ? ctrl : '0;

    assign o_pc_write      = ctrl_out.pc_write;
    assign o_pc_write_cond = ctrl_out.pc_write_cond;
    assign o_i_or_d        = ctrl_out.i_or_d;
    assign o_mem_read      = ctrl_out.mem_read;
    assign o_mem_write     = ctrl_out.mem_write;
    assign o_ir_write      = ctrl_out.ir_write;
    assign o_mem_to_reg    = ctrl_out.mem_to_reg;
    assign o_reg_dst       = ctrl_out.reg_dst;
    assign o_reg_write     = ctrl_out.reg_write;
    assign o_alu_src_a     = ctrl_out.alu_src_a;
    assign o_alu_src_b     = ctrl_out.alu_src_b;
    assign o_alu_op_code   = ctrl_out.alu_op;
    assign o_pc_src        = ctrl_out.pc_src;
    assign o_state         = state_q;
    assign o_illegal_op    = illegal_q;

endmodule

// File: tb/tb_control_unit_main_multicycle_mips.sv
// Self-checking bench: each instruction is expanded into its expected phase
// sequence (with memory wait/timeout behaviour) and every cycle is compared.
module tb_control_unit_main_multicycle_mips;

    localparam int TO = 4;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic [5:0] i_opcode = 6'h00;
    logic       i_mem_ready = 1'b0;
    logic       o_pc_write, o_pc_write_cond, o_i_or_d, o_mem_read, o_mem_write;
    logic       o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a;
    logic [1:0] o_alu_src_b, o_alu_op_code, o_pc_src;
    logic [3:0] o_state;
    logic       o_illegal_op, o_mem_timeout;
    logic [15:0] obs_ctrl;

    int tests = 0;
    int failed = 0;
    logic exp_ill = 1'b0;
    logic exp_to = 1'b0;

    always #5 i_clk = ~i_clk;

    control_unit_main_multicycle_mips #(.MEM_TIMEOUT(TO), .CNT_W(16)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_opcode(i_opcode), .i_mem_ready(i_mem_ready),
        .o_pc_write(o_pc_write), .o_pc_write_cond(o_pc_write_cond), .o_i_or_d(o_i_or_d),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_ir_write(o_ir_write),
        .o_mem_to_reg(o_mem_to_reg), .o_reg_dst(o_reg_dst), .o_reg_write(o_reg_write),
        .o_alu_src_a(o_alu_src_a), .o_alu_src_b(o_alu_src_b), .o_alu_op_code(o_alu_op_code),
        .o_pc_src(o_pc_src), .o_state(o_state), .o_illegal_op(o_illegal_op),
        .o_mem_timeout(o_mem_timeout)
    );

    assign obs_ctrl = {o_pc_write, o_pc_write_cond, o_i_or_d, o_mem_read, o_mem_write,
                       o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a,
                       o_alu_src_b, o_alu_op_code, o_pc_src};

    // Control table straight from the state descriptions, same bit order as obs_ctrl.
    function automatic logic [15:0] exp_ctrl(input int st, input logic rdy);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, psrc;
        pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; irw = 0; m2r = 0; rd = 0; rw = 0; asa = 0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rd = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
            9:  begin asa = 1; asb = 2'b10; end
            10: rw = 1;
            11: begin pcw = 1; psrc = 2'b10; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, psrc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive after the falling edge, compare, then let the rising edge pass.
    task automatic step(input int st, input logic rdy, input logic [5:0] op);
        @(negedge i_clk);
        i_mem_ready = rdy;
        i_opcode    = op;
        #1;
        check($sformatf("state@%0d", st), 32'(o_state), 32'(st));
        check($sformatf("ctrl@%0d", st), 32'(obs_ctrl), 32'(exp_ctrl(st, rdy)));
        check($sformatf("illegal@%0d", st), 32'(o_illegal_op), 32'(exp_ill));
        check($sformatf("timeout@%0d", st), 32'(o_mem_timeout), 32'(exp_to));
        exp_ill = 1'b0;
        exp_to  = 1'b0;
    endtask

    // A memory-handshake phase: nlow cycles of ready low, aborted once TO is reached.
    task automatic mem_phase(input int st, input int nlow, input logic [5:0] op, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < nlow && i < TO; i++) step(st, 1'b0, op);
        if (nlow >= TO) begin
            exp_to  = 1'b1;
            aborted = 1'b1;
        end else begin
            step(st, 1'b1, op);
        end
    endtask

    // Expand one instruction into its expected phases.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
        bit ab;
        mem_phase(0, wf, 6'($urandom), ab);
        if (ab) return;
        step(1, 1'($urandom), op);
        case (op)
            6'h23: begin
                step(2, 1'($urandom), op);
                mem_phase(3, wm, op, ab);
                if (!ab) step(4, 1'($urandom), op);
            end
            6'h2B: begin
                step(2, 1'($urandom), op);
                mem_phase(5, wm, op, ab);
            end
            6'h00: begin step(6, 1'($urandom), op); step(7, 1'($urandom), op); end
            6'h04: step(8, 1'($urandom), op);
            6'h08: begin step(9, 1'($urandom), op); step(10, 1'($urandom), op); end
            6'h02: step(11, 1'($urandom), op);
            default: exp_ill = 1'b1;
        endcase
    endtask

    initial begin
        logic [5:0] ops [7];
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
        ops[4] = 6'h08; ops[5] = 6'h02; ops[6] = 6'h3F;

        // Reset held low with ready high: everything quiet.
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            i_mem_ready = 1'b1;
            #1;
            check("reset_ctrl", 32'(obs_ctrl), 32'h0);
            check("reset_state", 32'(o_state), 32'h0);
            check("reset_pulses", 32'({o_illegal_op, o_mem_timeout}), 32'h0);
        end
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;

        // Directed cases.
        run_instr(6'h00, 0, 0);
        run_instr(6'h23, 0, 3);
        run_instr(6'h04, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h2B, 0, 4);
        run_instr(6'h2B, 0, 3);
        run_instr(6'h08, 1, 0);
        run_instr(6'h02, 0, 0);
        run_instr(6'h00, 4, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'h00, 4, 0);
        run_instr(6'h00, 4, 0);
        run_instr(6'h23, 2, 4);

        // Asynchronous reset in the middle of a store access.
        step(0, 1'b1, 6'h2B);
        step(1, 1'b0, 6'h2B);
        step(2, 1'b0, 6'h2B);
        step(5, 1'b0, 6'h2B);
        step(5, 1'b0, 6'h2B);
        #1 i_reset_n = 1'b0;
        #1;
        check("async_rst_mem_write", 32'(o_mem_write), 32'h0);
        check("async_rst_ctrl", 32'(obs_ctrl), 32'h0);
        check("async_rst_state", 32'(o_state), 32'h0);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_reset_n = 1'b1;
        // Fetch waits TO-1 cycles: only passes if the counter restarted at 0.
        run_instr(6'h2B, 3, 3);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            int wf, wm;
            op = ops[$urandom_range(0, 6)];
            if (op == 6'h3F) op = 6'($urandom);
            wf = ($urandom_range(0, 7) == 0) ? TO : int'($urandom_range(0, TO - 1));
            wm = ($urandom_range(0, 5) == 0) ? TO : int'($urandom_range(0, TO - 1));
            run_instr(op, wf, wm);
        end
        // Collect any pulse left pending by the final instruction.
        step(0, 1'b1, 6'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/control_unit_main_multicycle_mips.md
Name: control_unit_main_multicycle_mips

Overview:
- Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/writeback.
- Drives the ALU-control unit via o_alu_op_code (00 add, 01 sub, 10 funct-decoded).
- Drives datapath mux/write enables and handshakes with a wait-stated memory.
- Memory-timeout and illegal-opcode pulses feed the watchdog.

Parameters:
MEM_TIMEOUT, 255, cycles of i_mem_ready low tolerated in a memory state before abort (1..65535).
CNT_W, 16, width of wait counter (must satisfy 2^CNT_W > MEM_TIMEOUT).

Ports:
i_clk  input  1  clock, rising edge.
i_reset_n  input  1  asynchronous, active-low reset.
i_opcode  input  6  IR[31:26], valid from DECODE onward.
i_mem_ready  input  1  memory completes the current access this cycle.
o_pc_write, o_pc_write_cond, o_i_or_d, o_mem_read, o_mem_write, o_ir_write, o_mem_to_reg, o_reg_dst, o_reg_write, o_alu_src_a  output  1 each  datapath controls.
o_alu_src_b  output  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2.
o_alu_op_code  output  2  to ALU control.
o_pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
o_state  output  4  current state code, for debug/watchdog.
o_illegal_op  output  1  one-cycle pulse.
o_mem_timeout  output  1  one-cycle pulse.

Behaviour:
- State register and wait counter reset asynchronously: state FETCH (0), counter 0, pulse flops 0.
- While i_reset_n is low, all control outputs are forced to 0 and o_state is 0.
- Controls not listed for a state are 0.
- FETCH(0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write and pc_write = i_mem_ready (Mealy gating).
  - On ready -> DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by i_opcode:
  - 0x23/0x2B -> MEMADR
  - 0x00 -> EXECUTE
  - 0x04 -> BEQ
  - 0x08 -> ADDI_EX
  - 0x02 -> JUMP
  - else -> FETCH, with o_illegal_op=1 in the following cycle.
- MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: 0x23 -> MEMREAD; 0x2B -> MEMWRITE. Opcode is sampled again here and is required stable.
- MEMREAD(3): mem_read=1, i_or_d=1. On ready -> MEMWB.
- MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWRITE(5): mem_write=1, i_or_d=1. On ready -> FETCH.
- EXECUTE(6): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
- ALUWB(7): reg_dst=1, reg_write=1 -> FETCH.
- BEQ(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01 -> FETCH.
- ADDI_EX(9): alu_src_a=1, alu_src_b=10, alu_op=00 -> ADDI_WB.
- ADDI_WB(10): reg_dst=0, reg_write=1 -> FETCH.
- JUMP(11): pc_write=1, pc_src=10 -> FETCH.
- Codes 12-15 are unreachable. If entered: go to FETCH next cycle with o_illegal_op pulse.
- Latency, zero wait states: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3 cycles.
- Wait counter:
  - Cleared on every state transition.
  - Increments each cycle spent in FETCH/MEMREAD/MEMWRITE with i_mem_ready=0.
  - When counter == MEM_TIMEOUT-1 and ready still 0: next state FETCH, o_mem_timeout pulses the next cycle.
  - Aborted cycle asserts no ir_write/pc_write/reg_write.
  - Ready in the same cycle as the limit: ready wins, normal transition, no pulse.
- Reset mid-access: outputs drop to 0 immediately, asynchronously. After release the FSM restarts at FETCH with counter 0.
- Pulses are registered and last exactly one cycle even when consecutive faults occur back-to-back.

Decomposition:
- Shared package/header holds:
  - state codes S_FETCH..S_JUMP (4-bit);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALU op codes ALU_ADD=00, ALU_SUB=01, ALU_FUNCT=10;
  - alu_src_b and pc_src encodings.
- One sub-module, mem_wait_timer (counter + limit compare + timeout pulse flop), instantiated once.
- FSM next-state and output decode stay in the top module.

Test Plan:
- Reset held low 3 cycles, i_mem_ready=1 -> all outputs 0, o_state=0; first cycle after release: mem_read=1, ir_write=1, pc_write=1, alu_src_b=01.
- Opcode 0x00, ready=1 -> o_state sequence 0,1,6,7,0; in state 6 o_alu_op_code=10; reg_write=1 and reg_dst=1 only in state 7.
- Opcode 0x23, ready low 3 cycles in MEMREAD -> state 3 held 4 cycles, then 4 with mem_to_reg=1, reg_write=1; total 8 cycles.
- Opcode 0x04 -> state 8 with alu_op=01, pc_write_cond=1, pc_src=01; opcode 0x3F -> o_illegal_op single pulse, return to FETCH, no write enables.
- MEM_TIMEOUT=4, opcode 0x2B, ready stuck 0 -> 4 cycles in state 5, then state 0 with o_mem_timeout=1 for 1 cycle; repeat with ready rising on 4th cycle -> no pulse.
- Async reset asserted mid-MEMWRITE (between clock edges) -> mem_write falls immediately; after release FSM starts at FETCH with counter 0.
